// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between byte-stream requesters.
// A grant is locked until the owner flags its last byte, hits MAX_FRAME bytes,
// or leaves valid low for STALL_TO cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_FRAME  = 0,
  parameter int unsigned STALL_TO   = 0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   tx_send_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic                   stall_abort_o,
  output logic                   busy_o
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BYTE_W  = (MAX_FRAME > 0) ? $clog2(MAX_FRAME + 1) : 1;
  localparam int unsigned STALL_W = (STALL_TO > 0) ? $clog2(STALL_TO + 1) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOCKED  = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_GUARD   = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               frame_last_q, frame_last_d;
  logic               tx_send_d;
  logic [7:0]         tx_data_d;
  logic               stall_abort_d;
  logic               busy_d;
  logic               release_c;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_data;

  // Only the owner sees ready, and only while waiting for its next byte.
  assign req_ready_o = (state_q == S_LOCKED && tx_ready_i) ? grant_o : '0;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_q) + k) % NUM_REQ;
      if (!pick_found && req_valid_i[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Select the current owner's request signals.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_valid = req_valid_i[i];
        owner_last  = req_last_i[i];
        owner_data  = req_data_i[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    grant_d       = grant_o;
    byte_cnt_d    = byte_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_last_d  = frame_last_q;
    tx_send_d     = 1'b0;
    tx_data_d     = tx_data_o;
    stall_abort_d = 1'b0;
    release_c     = 1'b0;
    busy_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
          state_d     = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (owner_valid && tx_ready_i) begin
          tx_data_d    = owner_data;
          frame_last_d = owner_last;
          byte_cnt_d   = byte_cnt_q + BYTE_W'(1);
          stall_cnt_d  = '0;
          tx_send_d    = 1'b1;
          state_d      = S_SEND;
        end else if (!owner_valid) begin
          if (STALL_TO > 0 && stall_cnt_q == STALL_W'(STALL_TO - 1)) begin
            release_c     = 1'b1;
            stall_abort_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
        end
      end
      S_SEND:  state_d = S_GUARD;
      // uart_tx only drops ready after seeing the send, so skip one cycle.
      S_GUARD: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_ready_i) begin
          if (frame_last_q || (MAX_FRAME > 0 && byte_cnt_q == BYTE_W'(MAX_FRAME))) begin
            release_c = 1'b1;
          end else begin
            state_d = S_LOCKED;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (release_c) begin
      last_d    = owner_q;
      grant_d   = '0;
      gap_cnt_d = '0;
      state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      grant_o       <= '0;
      byte_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      frame_last_q  <= 1'b0;
      tx_send_o     <= 1'b0;
      tx_data_o     <= '0;
      stall_abort_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      grant_o       <= grant_d;
      byte_cnt_q    <= byte_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_last_q  <= frame_last_d;
      tx_send_o     <= tx_send_d;
      tx_data_o     <= tx_data_d;
      stall_abort_o <= stall_abort_d;
      busy_o        <= busy_d;
    end
  end

endmodule
